// File: rtl/hub_port_rx_if.sv
// Byte stream from a hub port receiver to the hub forwarding logic.
// Handshake: the producer holds byte_data/byte_last stable while byte_valid is
// high; a byte transfers on a rising edge where byte_valid && byte_ready, and
// byte_ready while byte_valid is low has no effect.
interface hub_port_rx_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_last;
    logic       byte_ready;

    modport master (
        output byte_data,
        output byte_valid,
        output byte_last,
        input  byte_ready
    );

    modport slave (
        input  byte_data,
        input  byte_valid,
        input  byte_last,
        output byte_ready
    );
endinterface

// File: rtl/hub_port_rx.sv
// Serial receive front end for one hub port: hunts for the start-of-frame
// delimiter, deserialises DATA_BYTES payload bytes LSB first and queues them
// in a small first-word-fall-through FIFO towards the forwarding logic.
// busy doubles as the FSM state observation point (high exactly in DATA).
module hub_port_rx #(
    parameter logic [7:0] SFD        = 8'hAB,
    parameter int         DATA_BYTES = 1,
    parameter int         FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    hub_port_rx_if.master     out,
    output logic              busy,
    output logic [15:0]       frame_count,
    output logic              overflow,
    input  logic              overflow_clr
);

    localparam int          AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [3:0]  LAST_IDX = 4'(DATA_BYTES - 1);

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    // Receiver state
    state_t      state_q,       state_d;
    logic [7:0]  hunt_q,        hunt_d;
    logic [2:0]  bit_cnt_q,     bit_cnt_d;
    logic [3:0]  byte_cnt_q,    byte_cnt_d;
    logic [7:0]  asm_q,         asm_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        overflow_q,    overflow_d;

    // FIFO state; each entry is {last, data}
    logic [8:0]  mem_q [FIFO_DEPTH];
    logic [8:0]  mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;

    // Push/pop strobes between the receiver and the FIFO
    logic [7:0]  hunt_shift;
    logic        push;
    logic        push_last;
    logic [7:0]  push_data;
    logic        pop;
    logic        full;
    logic        push_ok;

    assign hunt_shift = {hunt_q[6:0], rx};

    // Receiver FSM: delimiter hunt, then bit/byte assembly until the frame ends
    always_comb begin
        state_d       = state_q;
        hunt_d        = hunt_q;
        bit_cnt_d     = bit_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        asm_d         = asm_q;
        frame_count_d = frame_count_q;
        push          = 1'b0;
        push_last     = 1'b0;
        push_data     = 8'h00;

        case (state_q)
            ST_HUNT: begin
                if (hunt_shift == SFD) begin
                    // Clear the hunt window so the next frame needs a full fresh delimiter
                    state_d    = ST_DATA;
                    hunt_d     = 8'h00;
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = 4'd0;
                end else begin
                    hunt_d = hunt_shift;
                end
            end
            ST_DATA: begin
                // LSB first: each new sample enters at the top and moves down
                asm_d = {rx, asm_q[7:1]};
                if (bit_cnt_q == 3'd7) begin
                    push       = 1'b1;
                    push_data  = asm_d;
                    push_last  = (byte_cnt_q == LAST_IDX);
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = byte_cnt_q + 4'd1;
                    if (push_last) begin
                        // Counted even when the FIFO drops the byte
                        frame_count_d = frame_count_q + 16'd1;
                        state_d       = ST_HUNT;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase
    end

    assign pop     = (count_q != '0) && out.byte_ready;
    assign full    = (count_q == DEPTH_C);
    // A full FIFO still takes a byte if the head leaves on the same edge
    assign push_ok = push && (!full || pop);

    // FIFO pointers, occupancy and sticky overflow flag
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push_ok) begin
            mem_d[wr_ptr_q] = {push_last, push_data};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Set has priority over clear when both happen on one edge
        if (overflow_clr) begin
            overflow_d = 1'b0;
        end
        if (push && !push_ok) begin
            overflow_d = 1'b1;
        end
    end

    // State registers, all cleared by the asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_HUNT;
            hunt_q        <= 8'h00;
            bit_cnt_q     <= 3'd0;
            byte_cnt_q    <= 4'd0;
            asm_q         <= 8'h00;
            frame_count_q <= 16'd0;
            overflow_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 9'h000;
            end
        end else begin
            state_q       <= state_d;
            hunt_q        <= hunt_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            asm_q         <= asm_d;
            frame_count_q <= frame_count_d;
            overflow_q    <= overflow_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Head of FIFO is presented directly; data/last read as zero when empty
    always_comb begin
        out.byte_valid = (count_q != '0);
        out.byte_data  = out.byte_valid ? mem_q[rd_ptr_q][7:0] : 8'h00;
        out.byte_last  = out.byte_valid ? mem_q[rd_ptr_q][8]   : 1'b0;
    end

    assign busy        = (state_q == ST_DATA);
    assign frame_count = frame_count_q;
    assign overflow    = overflow_q;

endmodule
